// File: rtl/cu_readout.sv
// Readout sequencer: on a decoded read command, streams one TDC result
// packet (optional header byte, then PKT_BYTES RAM bytes) to the UART.
module cu_readout #(
  parameter int PKT_BYTES = 6,
  parameter int RAM_LAT   = 1,
  parameter int HDR_EN    = 1
) (
  input  logic       clk,
  input  logic       res,
  input  logic       cmd_read,
  input  logic       cmd_reset,
  input  logic       dev_sel,
  input  logic [4:0] pkt_addr,
  output logic       ram_rd,
  output logic [7:0] ram_addr,
  input  logic [7:0] ram_dout,
  output logic [7:0] tx_dout,
  output logic       tx_start,
  input  logic       tx_busy,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_TXW,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(PKT_BYTES - 1);
  // WAIT always occupies at least one cycle; longer latencies add cycles so
  // SEND lands on the first cycle ram_dout is valid (RAM_LAT after ram_rd,
  // with ram_rd raised on entry to FETCH).
  localparam logic [1:0] WAIT_LAST = 2'((RAM_LAT > 2) ? RAM_LAT - 2 : 0);

  state_t     state;
  logic [4:0] addr_l;
  logic [2:0] byte_idx;
  logic [1:0] wait_cnt;
  logic       txw_first;
  logic       hdr_phase;

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state     <= S_IDLE;
      addr_l    <= '0;
      byte_idx  <= '0;
      wait_cnt  <= '0;
      txw_first <= 1'b0;
      hdr_phase <= 1'b0;
      ram_rd    <= 1'b0;
      ram_addr  <= '0;
      tx_dout   <= '0;
      tx_start  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      ram_rd   <= 1'b0;
      tx_start <= 1'b0;
      done     <= 1'b0;
      overrun  <= cmd_read && (state != S_IDLE);

      if (cmd_reset) begin
        // Abort from any state; in IDLE this also drops a coincident read.
        state     <= S_IDLE;
        byte_idx  <= '0;
        txw_first <= 1'b0;
        hdr_phase <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_read && dev_sel) begin
              addr_l   <= pkt_addr;
              byte_idx <= '0;
              busy     <= 1'b1;
              if (HDR_EN != 0) begin
                state <= S_HDR;
              end else begin
                state    <= S_FETCH;
                ram_rd   <= 1'b1;
                ram_addr <= {pkt_addr, 3'd0};
              end
            end
          end
          S_HDR: begin
            if (!tx_busy) begin
              tx_dout   <= {3'b101, addr_l};
              tx_start  <= 1'b1;
              txw_first <= 1'b1;
              hdr_phase <= 1'b1;
              state     <= S_TXW;
            end
          end
          S_FETCH: begin
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            if (wait_cnt >= WAIT_LAST) begin
              state <= S_SEND;
            end else begin
              wait_cnt <= wait_cnt + 2'd1;
            end
          end
          S_SEND: begin
            if (!tx_busy) begin
              tx_dout   <= ram_dout;
              tx_start  <= 1'b1;
              txw_first <= 1'b1;
              hdr_phase <= 1'b0;
              state     <= S_TXW;
            end
          end
          S_TXW: begin
            if (txw_first) begin
              txw_first <= 1'b0;
            end else if (!tx_busy) begin
              if (hdr_phase) begin
                hdr_phase <= 1'b0;
                ram_rd    <= 1'b1;
                ram_addr  <= {addr_l, byte_idx};
                state     <= S_FETCH;
              end else if (byte_idx == LAST_IDX) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                byte_idx <= byte_idx + 3'd1;
                ram_rd   <= 1'b1;
                ram_addr <= {addr_l, byte_idx + 3'd1};
                state    <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
